// File: rtl/ram_256_b.sv
// rtl/ram_256_b.sv - 256-byte big-endian data memory with MFA/MFC handshake
// Byte, halfword and word loads/stores, unaligned and wrapping modulo 256.
module ram_256_b (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] data_out,
    output logic        MFC,
    input  logic        MFA,
    input  logic [5:0]  opcode,
    input  logic [7:0]  addr,
    input  logic [31:0] data_in
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    localparam logic [5:0] OP_LDUB = 6'h01;
    localparam logic [5:0] OP_LDSB = 6'h09;
    localparam logic [5:0] OP_LDUH = 6'h02;
    localparam logic [5:0] OP_LDSH = 6'h0A;
    localparam logic [5:0] OP_LD   = 6'h08;
    localparam logic [5:0] OP_STB  = 6'h05;
    localparam logic [5:0] OP_STH  = 6'h06;
    localparam logic [5:0] OP_ST   = 6'h04;

    logic [7:0]  ram [0:255];

    logic [1:0]  state_q, state_d;
    logic [5:0]  op_q, op_d;
    logic [7:0]  addr_q, addr_d;
    logic [31:0] din_q, din_d;
    logic [31:0] data_out_q, data_out_d;

    logic [7:0]  a0, a1, a2, a3;
    logic [7:0]  b0, b1, b2, b3;
    logic [31:0] load_val;
    logic        is_store;

    // Byte lanes of the latched access; the 8-bit adds wrap modulo 256.
    assign a0 = addr_q;
    assign a1 = addr_q + 8'd1;
    assign a2 = addr_q + 8'd2;
    assign a3 = addr_q + 8'd3;

    assign b0 = ram[a0];
    assign b1 = ram[a1];
    assign b2 = ram[a2];
    assign b3 = ram[a3];

    assign is_store = (op_q == OP_STB) || (op_q == OP_STH) || (op_q == OP_ST);

    always_comb begin
        load_val = 32'h0;
        case (op_q)
            OP_LDUB: load_val = {24'h0, b0};
            OP_LDSB: load_val = {{24{b0[7]}}, b0};
            OP_LDUH: load_val = {16'h0, b0, b1};
            OP_LDSH: load_val = {{16{b0[7]}}, b0, b1};
            OP_LD:   load_val = {b0, b1, b2, b3};
            default: load_val = 32'h0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        addr_d     = addr_q;
        din_d      = din_q;
        data_out_d = data_out_q;
        case (state_q)
            ST_IDLE: begin
                if (MFA) begin
                    op_d    = opcode;
                    addr_d  = addr;
                    din_d   = data_in;
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                // Stores keep the previous load result visible.
                if (!is_store) begin
                    data_out_d = load_val;
                end
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (!MFA) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            op_q       <= 6'h0;
            addr_q     <= 8'h0;
            din_q      <= 32'h0;
            data_out_q <= 32'h0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            din_q      <= din_d;
            data_out_q <= data_out_d;
        end
    end

    // All bytes of a store commit on the single edge leaving ACCESS.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) begin
                ram[i] <= 8'h00;
            end
        end else if (state_q == ST_ACCESS) begin
            case (op_q)
                OP_STB: begin
                    ram[a0] <= din_q[7:0];
                end
                OP_STH: begin
                    ram[a0] <= din_q[15:8];
                    ram[a1] <= din_q[7:0];
                end
                OP_ST: begin
                    ram[a0] <= din_q[31:24];
                    ram[a1] <= din_q[23:16];
                    ram[a2] <= din_q[15:8];
                    ram[a3] <= din_q[7:0];
                end
                default: ;
            endcase
        end
    end

    assign data_out = data_out_q;
    assign MFC      = (state_q == ST_DONE);

endmodule

// File: tb/tb_ram_256_b.sv
// tb/tb_ram_256_b.sv - self-checking bench for ram_256_b
// Byte-array model drives per-cycle MFC/data_out expectations plus literal pins.
module tb_ram_256_b;

    logic        clk;
    logic        rst_n;
    logic [31:0] data_out;
    logic        MFC;
    logic        MFA;
    logic [5:0]  opcode;
    logic [7:0]  addr;
    logic [31:0] data_in;

    int errors = 0;
    int checks = 0;

    logic [7:0]  mem_m [0:255];
    logic        exp_mfc;
    logic [31:0] exp_dout;
    bit          check_en;

    ram_256_b dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .data_out (data_out),
        .MFC      (MFC),
        .MFA      (MFA),
        .opcode   (opcode),
        .addr     (addr),
        .data_in  (data_in)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_load(input logic [5:0] op, input logic [7:0] a);
        logic [7:0] m0, m1, m2, m3;
        m0 = mem_m[a];
        m1 = mem_m[8'(a + 8'd1)];
        m2 = mem_m[8'(a + 8'd2)];
        m3 = mem_m[8'(a + 8'd3)];
        case (op)
            6'h01: return 32'(m0);
            6'h09: return 32'($signed(m0));
            6'h02: return 32'(m0) * 256 + 32'(m1);
            6'h0A: return 32'($signed({m0, m1}));
            6'h08: return ((32'(m0) * 256 + 32'(m1)) * 256 + 32'(m2)) * 256 + 32'(m3);
            default: return 32'h0;
        endcase
    endfunction

    function automatic int store_len(input logic [5:0] op);
        case (op)
            6'h05: return 1;
            6'h06: return 2;
            6'h04: return 4;
            default: return 0;
        endcase
    endfunction

    always @(negedge clk) begin
        if (check_en) begin
            chk("mfc", 32'(MFC), 32'(exp_mfc));
            chk("data_out", data_out, exp_dout);
        end
    end

    task automatic do_access(input logic [5:0] op, input logic [7:0] a, input logic [31:0] d,
                             input int hold, input bit use_lit, input logic [31:0] lit);
        int n;
        @(negedge clk);
        MFA = 1'b1; opcode = op; addr = a; data_in = d;
        @(posedge clk);
        #1;
        // Disturb inputs after the latch edge; the access must not notice.
        opcode = 6'h04; addr = ~a; data_in = 32'hDEADBEEF;
        @(posedge clk);
        n = store_len(op);
        if (n > 0) begin
            for (int i = 0; i < n; i++) begin
                mem_m[8'(a + 8'(i))] = 8'(d >> (8 * (n - 1 - i)));
            end
        end else begin
            exp_dout = model_load(op, a);
        end
        exp_mfc = 1'b1;
        #1;
        if (use_lit) chk("literal", data_out, lit);
        repeat (hold) @(posedge clk);
        @(negedge clk);
        MFA = 1'b0;
        @(posedge clk);
        exp_mfc = 1'b0;
    endtask

    task automatic check_mem(input string name);
        for (int i = 0; i < 256; i++) begin
            chk(name, 32'(dut.ram[i]), 32'(mem_m[i]));
        end
    endtask

    initial begin
        rst_n = 1'b0; MFA = 1'b0; opcode = 6'h0; addr = 8'h0; data_in = 32'h0;
        check_en = 1'b0; exp_mfc = 1'b0; exp_dout = 32'h0;
        for (int i = 0; i < 256; i++) mem_m[i] = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_mfc", 32'(MFC), 32'h0);
        chk("reset_dout", data_out, 32'h0);
        rst_n = 1'b1;
        check_en = 1'b1;
        check_mem("reset_ram");

        do_access(6'h05, 8'h00, 32'hFFFFFF01, 0, 1'b0, 32'h0);
        do_access(6'h05, 8'h01, 32'h00000023, 0, 1'b0, 32'h0);
        do_access(6'h06, 8'h02, 32'hAAAA4567, 0, 1'b0, 32'h0);
        do_access(6'h04, 8'h04, 32'h123ABCDF, 0, 1'b0, 32'h0);
        do_access(6'h08, 8'h00, 32'h0, 0, 1'b1, 32'h01234567);
        do_access(6'h08, 8'h04, 32'h0, 0, 1'b1, 32'h123ABCDF);
        do_access(6'h01, 8'h00, 32'h0, 0, 1'b1, 32'h00000001);
        do_access(6'h01, 8'h04, 32'h0, 0, 1'b1, 32'h00000012);
        do_access(6'h09, 8'h00, 32'h0, 0, 1'b1, 32'h00000001);
        do_access(6'h09, 8'h06, 32'h0, 0, 1'b1, 32'hFFFFFFBC);
        do_access(6'h02, 8'h03, 32'h0, 0, 1'b1, 32'h00006712);
        do_access(6'h02, 8'h06, 32'h0, 0, 1'b1, 32'h0000BCDF);
        do_access(6'h0A, 8'h02, 32'h0, 0, 1'b1, 32'h00004567);
        do_access(6'h0A, 8'h06, 32'h0, 0, 1'b1, 32'hFFFFBCDF);
        check_mem("image_ram");

        do_access(6'h04, 8'hFE, 32'hAABBCCDD, 0, 1'b0, 32'h0);
        do_access(6'h08, 8'hFE, 32'h0, 0, 1'b1, 32'hAABBCCDD);
        chk("wrap_ram00", 32'(dut.ram[0]), 32'h000000CC);
        chk("wrap_ram01", 32'(dut.ram[1]), 32'h000000DD);

        // MFA high for 10 edges: one store, MFC held until MFA drops.
        do_access(6'h04, 8'h40, 32'h5A5A1234, 8, 1'b0, 32'h0);
        do_access(6'h08, 8'h40, 32'h0, 0, 1'b1, 32'h5A5A1234);
        check_mem("hold_ram");

        // Reset pulse during ACCESS of a store.
        @(negedge clk);
        MFA = 1'b1; opcode = 6'h04; addr = 8'h10; data_in = 32'h11223344;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_mfc = 1'b0; exp_dout = 32'h0;
        for (int i = 0; i < 256; i++) mem_m[i] = 8'h00;
        #1;
        chk("rst_mfc", 32'(MFC), 32'h0);
        chk("rst_dout", data_out, 32'h0);
        MFA = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_mem("rst_ram");

        do_access(6'h04, 8'h20, 32'h0BADF00D, 0, 1'b0, 32'h0);
        do_access(6'h08, 8'h20, 32'h0, 0, 1'b1, 32'h0BADF00D);
        do_access(6'h3F, 8'h20, 32'h99999999, 0, 1'b1, 32'h00000000);
        check_mem("final_ram");

        @(negedge clk);
        check_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
